elevator: RTL and testbench



---
 rtl/elevator_if.sv | 31 +++
 rtl/elevator.sv | 112 +++++++++++
 tb/tb_elevator.sv | 125 ++++++++++++
 3 files changed

// File: rtl/elevator_if.sv
// Request/status bundle between the floor-request logic, the elevator
// controller and the motor/door actuator drivers.
interface elevator_if;
    logic       emergency_stop;
    logic [2:0] destiny_floor;
    logic       door;
    logic [2:0] current_floor;
    logic       moving_up;
    logic       moving_down;
    logic       emergency;

    modport master (
        output emergency_stop,
        output destiny_floor,
        input  door,
        input  current_floor,
        input  moving_up,
        input  moving_down,
        input  emergency
    );

    modport slave (
        input  emergency_stop,
        input  destiny_floor,
        output door,
        output current_floor,
        output moving_up,
        output moving_down,
        output emergency
    );
endinterface

// File: rtl/elevator.sv
// Single-car controller for an 8-floor shaft: one floor per FLOOR_CYCLES,
// door dwell of DOOR_CYCLES on arrival, and a freeze-and-resume emergency stop.
module elevator #(
    parameter int FLOOR_CYCLES = 2,
    parameter int DOOR_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    elevator_if.slave  bus
);
    localparam int TW = (FLOOR_CYCLES > 1) ? $clog2(FLOOR_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0] TLAST = TW'(FLOOR_CYCLES - 1);
    localparam logic [DW-1:0] DLAST = DW'(DOOR_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_UP, S_DOWN, S_DOOR, S_EMERG
    } state_t;

    state_t          r_state, r_resume, w_state, w_resume;
    logic [2:0]      r_floor, r_target, w_floor, w_target, w_step;
    logic [TW-1:0]   r_tcnt, w_tcnt;
    logic [DW-1:0]   r_dcnt, w_dcnt;
    logic            r_door, r_up, r_down, r_emerg;
    logic            w_door, w_up, w_down, w_emerg;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_resume <= S_IDLE;
            r_floor  <= 3'd0;
            r_target <= 3'd0;
            r_tcnt   <= '0;
            r_dcnt   <= '0;
            r_door   <= 1'b0;
            r_up     <= 1'b0;
            r_down   <= 1'b0;
            r_emerg  <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_resume <= w_resume;
            r_floor  <= w_floor;
            r_target <= w_target;
            r_tcnt   <= w_tcnt;
            r_dcnt   <= w_dcnt;
            r_door   <= w_door;
            r_up     <= w_up;
            r_down   <= w_down;
            r_emerg  <= w_emerg;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_resume = r_resume;
        w_floor  = r_floor;
        w_target = r_target;
        w_tcnt   = r_tcnt;
        w_dcnt   = r_dcnt;
        w_step   = r_floor;

        if (bus.emergency_stop) begin
            // Everything freezes; only remember where we came from.
            w_state = S_EMERG;
            if (r_state != S_EMERG) w_resume = r_state;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.destiny_floor != r_floor) begin
                        w_target = bus.destiny_floor;
                        w_tcnt   = '0;
                        w_state  = (bus.destiny_floor > r_floor) ? S_UP : S_DOWN;
                    end
                end
                S_UP, S_DOWN: begin
                    if (r_tcnt == TLAST) begin
                        w_step   = (r_state == S_UP) ? r_floor + 3'd1 : r_floor - 3'd1;
                        w_floor  = w_step;
                        w_tcnt   = '0;
                        // Destination is only re-sampled at a floor boundary.
                        w_target = bus.destiny_floor;
                        if (w_target == w_step) begin
                            w_state = S_DOOR;
                            w_dcnt  = '0;
                        end else begin
                            w_state = (w_target > w_step) ? S_UP : S_DOWN;
                        end
                    end else begin
                        w_tcnt = r_tcnt + 1'b1;
                    end
                end
                S_DOOR: begin
                    if (r_dcnt == DLAST) w_state = S_IDLE;
                    else                 w_dcnt  = r_dcnt + 1'b1;
                end
                S_EMERG: w_state = r_resume;
                default: w_state = S_IDLE;
            endcase
        end

        w_door  = (w_state == S_DOOR) || (w_state == S_EMERG && w_resume == S_DOOR);
        w_up    = (w_state == S_UP);
        w_down  = (w_state == S_DOWN);
        w_emerg = (w_state == S_EMERG);
    end

    assign bus.door          = r_door;
    assign bus.current_floor = r_floor;
    assign bus.moving_up     = r_up;
    assign bus.moving_down   = r_down;
    assign bus.emergency     = r_emerg;
endmodule

// File: tb/tb_elevator.sv
// Directed bench for the elevator controller at FLOOR_CYCLES=2, DOOR_CYCLES=2.
module tb_elevator;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    elevator_if bus ();

    elevator #(.FLOOR_CYCLES(2), .DOOR_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] f, input logic d,
                       input logic u, input logic dn, input logic e);
        logic [6:0] obs;
        logic [6:0] exp;
        obs = {bus.current_floor, bus.door, bus.moving_up, bus.moving_down, bus.emergency};
        exp = {f, d, u, dn, e};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed floor/door/up/down/emg=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic st(input string tag, input logic [2:0] f, input logic d,
                      input logic u, input logic dn, input logic e);
        @(posedge clk);
        #1;
        chk(tag, f, d, u, dn, e);
    endtask

    initial begin
        reset              = 1'b1;
        bus.emergency_stop = 1'b0;
        bus.destiny_floor  = 3'd0;
        st("reset", 0, 0, 0, 0, 0);
        reset = 1'b0;
        st("idle_hold0", 0, 0, 0, 0, 0);

        // 0 -> 1
        bus.destiny_floor = 3'd1;
        st("up1_e1", 0, 0, 1, 0, 0);
        st("up1_e2", 0, 0, 1, 0, 0);
        st("up1_arrive", 1, 1, 0, 0, 0);
        st("up1_door2", 1, 1, 0, 0, 0);
        st("up1_closed", 1, 0, 0, 0, 0);

        // 1 -> 4 with a one-cycle emergency mid-travel and one mid-dwell
        bus.destiny_floor = 3'd4;
        st("up4_e1", 1, 0, 1, 0, 0);
        st("up4_e2", 1, 0, 1, 0, 0);
        bus.emergency_stop = 1'b1;
        st("emg_travel", 1, 0, 0, 0, 1);
        bus.emergency_stop = 0;
        st("emg_resume", 1, 0, 1, 0, 0);
        st("up4_f2", 2, 0, 1, 0, 0);
        st("up4_f2b", 2, 0, 1, 0, 0);
        st("up4_f3", 3, 0, 1, 0, 0);
        st("up4_f3b", 3, 0, 1, 0, 0);
        st("up4_arrive", 4, 1, 0, 0, 0);
        bus.emergency_stop = 1'b1;
        st("emg_door", 4, 1, 0, 0, 1);
        bus.emergency_stop = 1'b0;
        st("door_resume", 4, 1, 0, 0, 0);
        st("door_last", 4, 1, 0, 0, 0);
        st("door_closed4", 4, 0, 0, 0, 0);

        // 4 -> 0; a request made while the door is open is ignored until IDLE
        bus.destiny_floor = 3'd0;
        st("dn0_e1", 4, 0, 0, 1, 0);
        st("dn0_e2", 4, 0, 0, 1, 0);
        st("dn0_f3", 3, 0, 0, 1, 0);
        st("dn0_f3b", 3, 0, 0, 1, 0);
        st("dn0_f2", 2, 0, 0, 1, 0);
        st("dn0_f2b", 2, 0, 0, 1, 0);
        st("dn0_f1", 1, 0, 0, 1, 0);
        st("dn0_f1b", 1, 0, 0, 1, 0);
        st("dn0_arrive", 0, 1, 0, 0, 0);
        bus.destiny_floor = 3'd2;
        st("door_ignores_req", 0, 1, 0, 0, 0);
        st("door_closed0", 0, 0, 0, 0, 0);
        st("req_after_close", 0, 0, 1, 0, 0);
        st("up2_e2", 0, 0, 1, 0, 0);
        st("up2_f1", 1, 0, 1, 0, 0);
        st("up2_f1b", 1, 0, 1, 0, 0);
        st("up2_arrive", 2, 1, 0, 0, 0);
        st("up2_door2", 2, 1, 0, 0, 0);
        st("up2_closed", 2, 0, 0, 0, 0);
        bus.destiny_floor = 3'd2;
        st("same_floor_no_open", 2, 0, 0, 0, 0);

        // 2 -> 6, retargeted to 1 between floors 2 and 3: reverse at 3
        bus.destiny_floor = 3'd6;
        st("rev_e1", 2, 0, 1, 0, 0);
        bus.destiny_floor = 3'd1;
        st("rev_between", 2, 0, 1, 0, 0);
        st("rev_f3_turn", 3, 0, 0, 1, 0);
        st("rev_f3b", 3, 0, 0, 1, 0);
        st("rev_f2", 2, 0, 0, 1, 0);
        st("rev_f2b", 2, 0, 0, 1, 0);
        st("rev_arrive1", 1, 1, 0, 0, 0);
        st("rev_door2", 1, 1, 0, 0, 0);
        st("rev_closed", 1, 0, 0, 0, 0);

        // reset while moving up at floor 2
        bus.destiny_floor = 3'd5;
        st("rst_e1", 1, 0, 1, 0, 0);
        st("rst_e2", 1, 0, 1, 0, 0);
        st("rst_f2", 2, 0, 1, 0, 0);
        reset = 1'b1;
        st("rst_abort", 0, 0, 0, 0, 0);
        reset = 1'b0;
        bus.destiny_floor = 3'd0;
        st("rst_idle", 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
